team_06_sram_model: RTL and testbench
=====================================

TEAM_06_SRAM_MODEL -- requirements
Module: team_06_sram_model

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, meaning word-address bits; depth is 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32, meaning word width in bits; legal values are multiples of 8, from 8 to 64.
REQ-003 SHALL have parameter RD_WAIT, default 1, meaning added read wait cycles; legal range 0-15.
REQ-004 SHALL have parameter WR_WAIT, default 1, meaning added write wait cycles; legal range 0-15.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port nrst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port address, input, 32 bits: byte address; word index = address[ADDR_W+1:2].
REQ-008 SHALL have port write_data, input, DATA_W bits: write data.
REQ-009 SHALL have port write_en, input, 1 bit: write request.
REQ-010 SHALL have port read_en, input, 1 bit: read request.
REQ-011 SHALL have port byte_select, input, DATA_W/8 bits: write byte-lane enables; bit i enables byte i.
REQ-012 SHALL have port read_data, output, DATA_W bits: registered read result.
REQ-013 SHALL have port busy, output, 1 bit: high while a request is in progress.
REQ-014 SHALL have port ack, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port err, output, 1 bit: one-cycle pulse marking a rejected request.

Function
REQ-016 SHALL implement the states IDLE and ACCESS plus a wait-cycle down-counter sized for max(RD_WAIT,WR_WAIT).
REQ-017 SHALL sample requests in IDLE only; read_en/write_en while in ACCESS are ignored (no err).
REQ-018 SHALL, on an accepted request at edge k, latch op, word index, write_data and byte_select, load the counter with RD_WAIT or WR_WAIT, enter ACCESS, and drive busy=1 from edge k.
REQ-019 SHALL, in ACCESS, decrement the counter each edge until it reaches 0.
REQ-020 SHALL perform the latched operation at the edge where the counter is 0 and return to IDLE at that same edge.
REQ-021 SHALL make ack=1 and busy=0 for exactly the one cycle after the operation edge.
REQ-022 SHALL, as a consequence, make ack visible WAIT+1 cycles after the request edge.
REQ-023 SHALL accept a new request sampled during the ack cycle (back-to-back throughput: one access per WAIT+2 cycles).
REQ-024 SHALL, on read completion, load read_data with the full memory word; read_data holds otherwise, including across writes.
REQ-025 SHALL, on write completion, update only the bytes whose byte_select bit is 1; byte_select=0 completes with ack and no change.
REQ-026 SHALL treat read_en and write_en both high in IDLE as illegal: err=1 for one cycle after the edge, no access, no busy, no ack.
REQ-027 SHALL treat a request with address[31:ADDR_W+2] != 0 as out of range: err=1 for one cycle, no access, no busy, no ack.
REQ-028 SHALL ignore address[1:0] (word-aligned access).
REQ-029 SHALL initialise the memory array to all zero at time 0 (simulation model; not synthesised as SRAM macro).
REQ-030 SHALL make ack and err mutually exclusive in any cycle.

Reset
REQ-031 SHALL, while nrst=0, force state=IDLE, counter=0, read_data=0, busy=0, ack=0, err=0.
REQ-032 SHALL, on reset during ACCESS, abort the request: no memory write, no ack; memory contents are retained.
REQ-033 SHALL sample the first request at the first rising edge after nrst deasserts.

Verification
REQ-034 Default params: write 0xDEADBEEF at address 0x10 with byte_select=4'hF, then read 0x10 -> each op busy 2 cycles, ack 2 cycles after request, read_data=0xDEADBEEF.
REQ-035 Over the word from REQ-034, write 0x11223344 with byte_select=4'b0101, then read -> read_data=0xDE22BE44.
REQ-036 RD_WAIT=0, WR_WAIT=3: read acks 1 cycle after request; write acks 4 cycles after request; read_en pulses during the write are ignored.
REQ-037 read_en=write_en=1 at 0x20 -> err pulse, busy stays 0, no ack; address 0x8000 (ADDR_W=13) -> err pulse, memory unchanged.
REQ-038 Assert nrst=0 mid-write to 0x40 -> outputs 0 immediately; later read of 0x40 returns the pre-write value.
REQ-039 DATA_W=64, ADDR_W=4: fill all 16 words, read back; address 0x3C vs 0x40 -> word 15 accessed vs err.

Source files
------------

// File: rtl/team_06_sram_model.sv
// Word-addressed SRAM simulation model with programmable read/write wait
// states, byte-lane writes, and rejection of illegal or out-of-range requests.
module team_06_sram_model #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 32,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [31:0]         address,
    input  logic [DATA_W-1:0]   write_data,
    input  logic                write_en,
    input  logic                read_en,
    input  logic [DATA_W/8-1:0] byte_select,
    output logic [DATA_W-1:0]   read_data,
    output logic                busy,
    output logic                ack,
    output logic                err
);
    localparam int LANES    = DATA_W / 8;
    localparam int DEPTH    = 2 ** ADDR_W;
    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic                op_write;
    logic [ADDR_W-1:0]   idx;
    logic [DATA_W-1:0]   wdata_q;
    logic [LANES-1:0]    bsel_q;

    logic [DATA_W-1:0]   mem [DEPTH] = '{default: '0};

    logic in_range;
    logic req_any;
    logic req_bad;
    logic accept;
    logic do_op;

    assign in_range = (address >> (ADDR_W + 2)) == 32'd0;
    assign req_any  = read_en | write_en;
    assign req_bad  = (read_en & write_en) | (req_any & ~in_range);
    assign accept   = (state == IDLE) & req_any & ~req_bad;
    assign do_op    = (state == ACCESS) && (cnt == '0);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is assigned a default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (accept) state_next = ACCESS;
            ACCESS: if (cnt == '0) state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ACCESS);
    end

    // Request latch, wait counter and registered response pulses.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt       <= '0;
            op_write  <= 1'b0;
            idx       <= '0;
            wdata_q   <= '0;
            bsel_q    <= '0;
            read_data <= '0;
            ack       <= 1'b0;
            err       <= 1'b0;
        end else begin
            ack <= do_op;
            err <= (state == IDLE) && req_bad;
            if (accept) begin
                op_write <= write_en;
                idx      <= address[ADDR_W+1:2];
                wdata_q  <= write_data;
                bsel_q   <= byte_select;
                cnt      <= write_en ? CNT_W'(WR_WAIT) : CNT_W'(RD_WAIT);
            end else if ((state == ACCESS) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (do_op && !op_write) begin
                read_data <= mem[idx];
            end
        end
    end

    // NOTE: the array is deliberately left out of reset; an access aborted by nrst must leave it intact.
    always_ff @(posedge clk) begin
        if (do_op && op_write) begin
            for (int i = 0; i < LANES; i++) begin
                if (bsel_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_team_06_sram_model.sv
// Randomised bench for team_06_sram_model: three instances (default, slow-write,
// 64-bit narrow-address) compared against a byte-lane memory model.
module tb_team_06_sram_model;
    localparam int HALF   = 5;
    localparam int PERIOD = 2 * HALF;

    logic clk = 1'b0;
    logic nrst;
    always #HALF clk = ~clk;

    logic [31:0] a0, a1, a2;
    logic [31:0] wd0, wd1, rd0, rd1;
    logic [63:0] wd2, rd2;
    logic        we0, we1, we2, re0, re1, re2;
    logic [3:0]  bs0, bs1;
    logic [7:0]  bs2;
    logic        busy0, busy1, busy2, ack0, ack1, ack2, err0, err1, err2;

    team_06_sram_model d0 (
        .clk(clk), .nrst(nrst), .address(a0), .write_data(wd0), .write_en(we0),
        .read_en(re0), .byte_select(bs0), .read_data(rd0), .busy(busy0), .ack(ack0), .err(err0)
    );
    team_06_sram_model #(.RD_WAIT(0), .WR_WAIT(3)) d1 (
        .clk(clk), .nrst(nrst), .address(a1), .write_data(wd1), .write_en(we1),
        .read_en(re1), .byte_select(bs1), .read_data(rd1), .busy(busy1), .ack(ack1), .err(err1)
    );
    team_06_sram_model #(.ADDR_W(4), .DATA_W(64)) d2 (
        .clk(clk), .nrst(nrst), .address(a2), .write_data(wd2), .write_en(we2),
        .read_en(re2), .byte_select(bs2), .read_data(rd2), .busy(busy2), .ack(ack2), .err(err2)
    );

    typedef struct packed {
        logic [63:0] rd;
        logic        busy;
        logic        ack;
        logic        err;
    } obs_t;

    int  checks   = 0;
    int  failures = 0;
    time req_t;

    logic [63:0] m0 [int];
    logic [63:0] m1 [int];
    logic [63:0] m2 [int];

    function automatic int wait_of(input int sel, input logic wr);
        if (sel == 1) return wr ? 3 : 0;
        return 1;
    endfunction

    function automatic int lanes_of(input int sel);
        return (sel == 2) ? 8 : 4;
    endfunction

    function automatic logic [63:0] model_get(input int sel, input int idx);
        case (sel)
            0:       return m0.exists(idx) ? m0[idx] : 64'd0;
            1:       return m1.exists(idx) ? m1[idx] : 64'd0;
            default: return m2.exists(idx) ? m2[idx] : 64'd0;
        endcase
    endfunction

    task automatic model_write(input int sel, input int idx, input logic [63:0] wd, input logic [7:0] bs);
        logic [63:0] cur;
        cur = model_get(sel, idx);
        for (int b = 0; b < lanes_of(sel); b++) begin
            if (bs[b]) cur[8*b +: 8] = wd[8*b +: 8];
        end
        case (sel)
            0:       m0[idx] = cur;
            1:       m1[idx] = cur;
            default: m2[idx] = cur;
        endcase
    endtask

    task automatic drive(input int sel, input logic [31:0] a, input logic [63:0] wd,
                         input logic we, input logic re, input logic [7:0] bs);
        case (sel)
            0: begin a0 = a; wd0 = wd[31:0]; we0 = we; re0 = re; bs0 = bs[3:0]; end
            1: begin a1 = a; wd1 = wd[31:0]; we1 = we; re1 = re; bs1 = bs[3:0]; end
            default: begin a2 = a; wd2 = wd; we2 = we; re2 = re; bs2 = bs; end
        endcase
    endtask

    task automatic idle(input int sel);
        drive(sel, 32'd0, 64'd0, 1'b0, 1'b0, 8'd0);
    endtask

    function automatic obs_t sample(input int sel);
        case (sel)
            0:       return {{32'd0, rd0}, busy0, ack0, err0};
            1:       return {{32'd0, rd1}, busy1, ack1, err1};
            default: return {rd2, busy2, ack2, err2};
        endcase
    endfunction

    // One complete access; b2b drives on the current negedge instead of waiting for the next.
    task automatic do_access(input int sel, input string name, input logic [31:0] a,
                             input logic [63:0] wd, input logic we, input logic [7:0] bs,
                             input bit poke, input bit b2b, output logic [63:0] rd);
        int   wait_n, n, busy_n, idx;
        bit   err_seen;
        obs_t o;
        wait_n = wait_of(sel, we);
        idx    = int'(a >> 2);
        if (!b2b) @(negedge clk);
        drive(sel, a, wd, we, !we, bs);
        @(posedge clk);
        req_t = $time;
        @(negedge clk);
        idle(sel);
        n = 0; busy_n = 0; err_seen = 0;
        o = sample(sel);
        while (!o.ack && n <= 40) begin
            if (o.busy) busy_n++;
            if (o.err) err_seen = 1;
            if (poke) drive(sel, a, 64'd0, 1'b0, 1'b1, 8'd0);
            @(posedge clk);
            @(negedge clk);
            idle(sel);
            n++;
            o = sample(sel);
        end
        if (o.err) err_seen = 1;
        rd = o.rd;
        checks++;
        if (n !== wait_n + 1) begin
            failures++;
            $display("FAIL %s ack_latency got=%0d exp=%0d", name, n, wait_n + 1);
        end
        checks++;
        if (busy_n !== wait_n + 1 || o.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d exp=%0d busy_at_ack=%b", name, busy_n, wait_n + 1, o.busy);
        end
        checks++;
        if (err_seen !== 1'b0) begin
            failures++;
            $display("FAIL %s unexpected_err got=1 exp=0", name);
        end
        if (!we) begin
            checks++;
            if (o.rd !== model_get(sel, idx)) begin
                failures++;
                $display("FAIL %s read_data got=%h exp=%h", name, o.rd, model_get(sel, idx));
            end
        end else begin
            model_write(sel, idx, wd, bs);
        end
    endtask

    task automatic do_reject(input int sel, input string name, input logic [31:0] a,
                             input logic we, input logic re);
        obs_t o;
        @(negedge clk);
        drive(sel, a, {$urandom, $urandom}, we, re, 8'hFF);
        @(posedge clk);
        @(negedge clk);
        idle(sel);
        o = sample(sel);
        checks++;
        if (o.err !== 1'b1 || o.busy !== 1'b0 || o.ack !== 1'b0) begin
            failures++;
            $display("FAIL %s reject_cycle got err=%b busy=%b ack=%b exp err=1 busy=0 ack=0", name, o.err, o.busy, o.ack);
        end
        @(posedge clk);
        @(negedge clk);
        o = sample(sel);
        checks++;
        if (o.err !== 1'b0 || o.busy !== 1'b0 || o.ack !== 1'b0) begin
            failures++;
            $display("FAIL %s after_reject got err=%b busy=%b ack=%b exp all 0", name, o.err, o.busy, o.ack);
        end
    endtask

    task automatic test_reset();
        obs_t        o;
        logic [63:0] rd;
        nrst = 1'b0;
        for (int s = 0; s < 3; s++) idle(s);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            o = sample(s);
            checks++;
            if (o !== '0) begin
                failures++;
                $display("FAIL reset_outputs dut=%0d got rd=%h busy=%b ack=%b err=%b exp all 0", s, o.rd, o.busy, o.ack, o.err);
            end
        end
        nrst = 1'b1;
        do_access(0, "first_after_reset", 32'h100, 64'd0, 1'b0, 8'd0, 0, 1, rd);
    endtask

    task automatic test_basic();
        logic [63:0] rd;
        do_access(0, "full_write", 32'h10, 64'hDEADBEEF, 1'b1, 8'hF, 0, 0, rd);
        do_access(0, "full_read", 32'h10, 64'd0, 1'b0, 8'd0, 0, 0, rd);
        checks++;
        if (rd[31:0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL full_read_const got=%h exp=deadbeef", rd[31:0]);
        end
        do_access(0, "lane_write", 32'h10, 64'h11223344, 1'b1, 8'h5, 0, 0, rd);
        do_access(0, "lane_read", 32'h13, 64'd0, 1'b0, 8'd0, 0, 0, rd);
        checks++;
        if (rd[31:0] !== 32'hDE22BE44) begin
            failures++;
            $display("FAIL lane_read_const got=%h exp=de22be44", rd[31:0]);
        end
        do_access(0, "zero_lane_write", 32'h10, 64'hFFFFFFFF, 1'b1, 8'h0, 0, 0, rd);
        do_access(0, "zero_lane_read", 32'h10, 64'd0, 1'b0, 8'd0, 0, 0, rd);
    endtask

    task automatic test_wait_states();
        logic [63:0] rd;
        do_access(1, "slow_rd_init", 32'h8, 64'd0, 1'b0, 8'd0, 0, 0, rd);
        do_access(1, "slow_wr_poked", 32'h8, 64'hCAFEF00D, 1'b1, 8'hF, 1, 0, rd);
        do_access(1, "slow_rd_back", 32'h8, 64'd0, 1'b0, 8'd0, 0, 0, rd);
    endtask

    task automatic test_errors();
        logic [63:0] rd;
        do_reject(0, "both_en", 32'h20, 1'b1, 1'b1);
        do_access(0, "both_en_readback", 32'h20, 64'd0, 1'b0, 8'd0, 0, 0, rd);
        do_reject(0, "out_of_range", 32'h8000, 1'b1, 1'b0);
        do_access(0, "alias_word0_read", 32'h0, 64'd0, 1'b0, 8'd0, 0, 0, rd);
    endtask

    task automatic test_hold();
        logic [63:0] rd, held;
        obs_t        o;
        do_access(0, "hold_rd", 32'h10, 64'd0, 1'b0, 8'd0, 0, 0, held);
        do_access(0, "hold_wr", 32'h10, 64'h55667788, 1'b1, 8'hF, 0, 0, rd);
        checks++;
        if (rd !== held) begin
            failures++;
            $display("FAIL read_data_hold got=%h exp=%h", rd, held);
        end
        @(posedge clk);
        @(negedge clk);
        o = sample(0);
        checks++;
        if (o.ack !== 1'b0 || o.busy !== 1'b0) begin
            failures++;
            $display("FAIL ack_single_cycle got ack=%b busy=%b exp 0 0", o.ack, o.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd;
        time         t0;
        do_access(0, "b2b_wr", 32'h60, 64'h0F1E2D3C, 1'b1, 8'hF, 0, 0, rd);
        t0 = req_t;
        do_access(0, "b2b_rd", 32'h60, 64'd0, 1'b0, 8'd0, 0, 1, rd);
        checks++;
        if (req_t - t0 !== 3 * PERIOD) begin
            failures++;
            $display("FAIL b2b_spacing_default got=%0t exp=%0t", req_t - t0, 3 * PERIOD);
        end
        do_access(1, "b2b_fast_rd0", 32'h8, 64'd0, 1'b0, 8'd0, 0, 0, rd);
        t0 = req_t;
        do_access(1, "b2b_fast_rd1", 32'h8, 64'd0, 1'b0, 8'd0, 0, 1, rd);
        checks++;
        if (req_t - t0 !== 2 * PERIOD) begin
            failures++;
            $display("FAIL b2b_spacing_rd0 got=%0t exp=%0t", req_t - t0, 2 * PERIOD);
        end
    endtask

    task automatic test_random();
        logic [63:0] rd, wd;
        logic [31:0] a;
        logic [7:0]  bs;
        int          sel;
        for (int i = 0; i < 40; i++) begin
            sel = i % 2;
            a   = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            wd  = {$urandom, $urandom};
            bs  = 8'($urandom);
            do_access(sel, "random", a, wd, 1'($urandom_range(0, 1)), bs, 0, 1'($urandom_range(0, 1)), rd);
        end
    endtask

    task automatic test_reset_abort();
        logic [63:0] rd;
        obs_t        o;
        do_access(0, "abort_pre_wr", 32'h40, 64'hA5A55A5A, 1'b1, 8'hF, 0, 0, rd);
        do_access(0, "abort_pre_rd", 32'h40, 64'd0, 1'b0, 8'd0, 0, 0, rd);
        @(negedge clk);
        drive(0, 32'h40, 64'h0BADF00D, 1'b1, 1'b0, 8'hF);
        @(posedge clk);
        @(negedge clk);
        idle(0);
        o = sample(0);
        checks++;
        if (o.busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy_before got=%b exp=1", o.busy);
        end
        nrst = 1'b0;
        #1;
        o = sample(0);
        checks++;
        if (o !== '0) begin
            failures++;
            $display("FAIL abort_outputs got rd=%h busy=%b ack=%b err=%b exp all 0", o.rd, o.busy, o.ack, o.err);
        end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        do_access(0, "abort_readback", 32'h40, 64'd0, 1'b0, 8'd0, 0, 1, rd);
        checks++;
        if (rd[31:0] !== 32'hA5A55A5A) begin
            failures++;
            $display("FAIL abort_retained got=%h exp=a5a55a5a", rd[31:0]);
        end
    endtask

    task automatic test_wide();
        logic [63:0] rd;
        for (int i = 0; i < 16; i++) begin
            do_access(2, "wide_fill", 32'(i) << 2, {$urandom, $urandom}, 1'b1, 8'hFF, 0, 0, rd);
        end
        do_access(2, "wide_lanes", 32'h14, 64'h0123456789ABCDEF, 1'b1, 8'hA5, 0, 0, rd);
        for (int i = 0; i < 16; i++) begin
            do_access(2, "wide_readback", 32'(i) << 2, 64'd0, 1'b0, 8'd0, 0, 0, rd);
        end
        do_access(2, "wide_top_word", 32'h3C, 64'd0, 1'b0, 8'd0, 0, 0, rd);
        do_access(2, "wide_top_unaligned", 32'h3F, 64'd0, 1'b0, 8'd0, 0, 0, rd);
        do_reject(2, "wide_out_of_range", 32'h40, 1'b0, 1'b1);
        do_access(2, "wide_word0_intact", 32'h0, 64'd0, 1'b0, 8'd0, 0, 0, rd);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_errors();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_abort();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
